fir_mac_sequencer: RTL and testbench

//  Time-multiplexed FIR filter controller around one multiplier + accumulator pair.

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_accum.sv | 21 ++
 rtl/fir_delay_line.sv | 35 +++
 rtl/fir_mult.sv | 12 +
 rtl/fir_mac_sequencer.sv | 148 ++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR MAC sequencer.
// Holds the sequencer state encoding and the tap-index width helper.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int tap_bits(input int taps);
    return (taps < 2) ? 1 : $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_accum.sv
// Wrapping accumulator: load replaces the sum, otherwise en adds din modulo 2^DW.
module fir_accum #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          en,
  input  logic          load,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] sum
);

  always_ff @(posedge clk) begin
    if (clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= load ? din : sum + din;
    end
  end

endmodule

// File: rtl/fir_delay_line.sv
// TAPS-deep circular sample buffer with a write pointer and a combinational read port.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int TAPS = 8,
  localparam int AW   = tap_bits(TAPS)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          we,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] rd_idx,
  output logic [W-1:0]  rdata,
  output logic [AW-1:0] wr_ptr
);

  logic [W-1:0] mem [TAPS];

  // Clearing the whole line makes any history from before the reset read as zero.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < TAPS; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (we) begin
      mem[wr_ptr] <= wdata;
      wr_ptr      <= wr_ptr + AW'(1);
    end
  end

  assign rdata = mem[rd_idx];

endmodule

// File: rtl/fir_mult.sv
// Unsigned W x W multiplier producing a full 2W-bit product.
module fir_mult #(
  parameter int W = 16
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product
);

  assign product = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller sharing one multiplier and accumulator across TAPS products per sample.
// Accepts a sample in IDLE, walks the taps in MAC, presents y[n] in DONE until taken.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int TAPS = 8,
  localparam int AW   = tap_bits(TAPS)
) (
  input  logic           clk,
  input  logic           clear,
  input  logic           sample_valid,
  output logic           sample_ready,
  input  logic [W-1:0]   sample_data,
  input  logic           coef_we,
  input  logic [AW-1:0]  coef_addr,
  input  logic [W-1:0]   coef_data,
  output logic           coef_ready,
  output logic           result_valid,
  input  logic           result_ready,
  output logic [2*W-1:0] result_data,
  output logic           busy
);

  state_t state, next_state;

  logic           accept;
  logic           mac_en;
  logic           load_q;
  logic [AW-1:0]  tap;
  logic [AW-1:0]  base;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_idx;
  logic [W-1:0]   x_tap;
  logic [W-1:0]   h_tap;
  logic [W-1:0]   coef [TAPS];
  logic [2*W-1:0] product;
  logic [2*W-1:0] acc;

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    sample_ready = 1'b0;
    coef_ready   = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    accept       = 1'b0;
    mac_en       = 1'b0;
    case (state)
      IDLE: begin
        sample_ready = 1'b1;
        coef_ready   = 1'b1;
        accept       = sample_valid;
        if (sample_valid) begin
          next_state = MAC;
        end
      end
      MAC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (tap == AW'(TAPS - 1)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // load_q is one cycle behind accept so the first product overwrites the previous sum.
  always_ff @(posedge clk) begin
    if (clear) begin
      tap    <= '0;
      base   <= '0;
      load_q <= 1'b0;
    end else begin
      load_q <= accept;
      if (accept) begin
        tap  <= '0;
        base <= wr_ptr;
      end else if (mac_en) begin
        tap <= tap + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < TAPS; i++) begin
        coef[i] <= '0;
      end
    end else if (coef_we && coef_ready) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // Walking backwards from the newest sample gives x[n-k]; AW-bit arithmetic wraps the index.
  assign rd_idx = base - tap;
  assign h_tap  = coef[tap];

  fir_delay_line #(
    .W    (W),
    .TAPS (TAPS)
  ) u_delay_line (
    .clk    (clk),
    .clear  (clear),
    .we     (accept),
    .wdata  (sample_data),
    .rd_idx (rd_idx),
    .rdata  (x_tap),
    .wr_ptr (wr_ptr)
  );

  fir_mult #(
    .W (W)
  ) u_mult (
    .a       (h_tap),
    .b       (x_tap),
    .product (product)
  );

  fir_accum #(
    .DW (2 * W)
  ) u_accum (
    .clk   (clk),
    .clear (clear),
    .en    (mac_en),
    .load  (load_q),
    .din   (product),
    .sum   (acc)
  );

  assign result_data = acc;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with TAPS=4, W=16: vector table plus corner sequences.
module tb_fir_mac_sequencer;

  localparam int W    = 16;
  localparam int TAPS = 4;
  localparam int AW   = 2;

  logic           clk = 1'b0;
  logic           clear = 1'b0;
  logic           sample_valid = 1'b0;
  logic           sample_ready;
  logic [W-1:0]   sample_data = '0;
  logic           coef_we = 1'b0;
  logic [AW-1:0]  coef_addr = '0;
  logic [W-1:0]   coef_data = '0;
  logic           coef_ready;
  logic           result_valid;
  logic           result_ready = 1'b1;
  logic [2*W-1:0] result_data;
  logic           busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]   sample;
    logic [2*W-1:0] expected;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  fir_mac_sequencer #(
    .W    (W),
    .TAPS (TAPS)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .coef_ready   (coef_ready),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .busy         (busy)
  );

  task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                             input logic [2*W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic doClear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic writeCoef(input logic [AW-1:0] k, input logic [W-1:0] d);
    coef_we   = 1'b1;
    coef_addr = k;
    coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic loadCoefs(input logic [W-1:0] h0, input logic [W-1:0] h1,
                           input logic [W-1:0] h2, input logic [W-1:0] h3);
    writeCoef(2'd0, h0);
    writeCoef(2'd1, h1);
    writeCoef(2'd2, h2);
    writeCoef(2'd3, h3);
  endtask

  // mode 0: plain; 1: coef[0]=9 write attempted during MAC; 2: hold in DONE 3 cycles;
  // 3: coef[0]=6 written in the same cycle as the sample accept.
  task automatic applyStimulus(input logic [W-1:0] sample, input logic [2*W-1:0] expected,
                               input string name, input int mode);
    int n;
    int guard;
    guard = 0;
    while (!sample_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkBit({name, "_ready_before"}, sample_ready, 1'b1);
    if (sample_ready !== 1'b1) return;
    sample_valid = 1'b1;
    sample_data  = sample;
    if (mode == 3) begin
      coef_we   = 1'b1;
      coef_addr = 2'd0;
      coef_data = 16'd6;
    end
    if (mode == 2) result_ready = 1'b0;
    @(negedge clk);
    sample_valid = 1'b0;
    coef_we      = 1'b0;
    n            = 1;
    checkBit({name, "_busy"}, busy, 1'b1);
    checkBit({name, "_ready_in_mac"}, sample_ready, 1'b0);
    if (mode == 1) begin
      coef_we   = 1'b1;
      coef_addr = 2'd0;
      coef_data = 16'd9;
      checkBit({name, "_coef_ready_in_mac"}, coef_ready, 1'b0);
    end
    while (!result_valid && n < 20) begin
      @(negedge clk);
      coef_we = 1'b0;
      n++;
    end
    checkOutput({name, "_latency"}, 32'(n), 32'(TAPS + 1));
    checkOutput({name, "_data"}, result_data, expected);
    if (mode == 2) begin
      for (int c = 0; c < 3; c++) begin
        sample_valid = 1'b1;
        sample_data  = 16'h00AA;
        @(negedge clk);
        checkBit({name, "_held_valid"}, result_valid, 1'b1);
        checkOutput({name, "_held_data"}, result_data, expected);
        checkBit({name, "_held_ready"}, sample_ready, 1'b0);
      end
      sample_valid = 1'b0;
      result_ready = 1'b1;
    end
    @(negedge clk);
    checkBit({name, "_valid_drops"}, result_valid, 1'b0);
    checkBit({name, "_ready_after"}, sample_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{16'd5,      32'd5};
    vecs[1] = '{16'd7,      32'd17};
    vecs[2] = '{16'd0,      32'd29};
    vecs[3] = '{16'd0,      32'd41};
    vecs[4] = '{16'hFFFF,   32'hFFFE0001};
    vecs[5] = '{16'hFFFF,   32'hFFFC0002};
    vecs[6] = '{16'hFFFF,   32'hFFFA0003};
    vecs[7] = '{16'hFFFF,   32'hFFF80004};

    doClear();
    checkBit("reset_sample_ready", sample_ready, 1'b1);
    checkBit("reset_coef_ready", coef_ready, 1'b1);
    checkBit("reset_result_valid", result_valid, 1'b0);
    checkBit("reset_busy", busy, 1'b0);
    checkOutput("reset_result_data", result_data, 32'd0);

    loadCoefs(16'd1, 16'd2, 16'd3, 16'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].sample, vecs[i].expected, $sformatf("vec%0d", i), 0);
    end

    applyStimulus(16'd1, 32'd29, "backpressure", 2);

    applyStimulus(16'd2, 32'd4, "mac_coef_write", 1);
    applyStimulus(16'd3, 32'd10, "old_h0_kept", 0);

    sample_valid = 1'b1;
    sample_data  = 16'd5;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    checkBit("midmac_busy", busy, 1'b1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkBit("midmac_clear_ready", sample_ready, 1'b1);
    checkBit("midmac_clear_valid", result_valid, 1'b0);
    checkBit("midmac_clear_busy", busy, 1'b0);
    checkOutput("midmac_clear_data", result_data, 32'd0);
    loadCoefs(16'd1, 16'd2, 16'd3, 16'd4);
    applyStimulus(16'd3, 32'd3, "after_clear", 0);

    doClear();
    applyStimulus(16'd2, 32'd12, "same_cycle_coef", 3);

    doClear();
    loadCoefs(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    for (int i = 4; i < 8; i++) begin
      applyStimulus(vecs[i].sample, vecs[i].expected, $sformatf("vec%0d", i), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
